// File: rtl/sub_arbiter_pkg.sv
// Shared types and default sizing for the round-robin subtractor arbiter.
package sub_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;
  localparam int TXN_W     = 16;

endpackage

// File: rtl/sub_arbiter_subtractor.sv
// Combinational A-B with borrow-out; all arithmetic of the arbiter lives here.
module subtractor
  import sub_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] OUT,
  output logic             BORROW
);

  logic [WIDTH:0] diff;

  // One extra bit so the top bit of the difference is the unsigned borrow.
  assign diff   = {1'b0, A} - {1'b0, B};
  assign OUT    = diff[WIDTH-1:0];
  assign BORROW = diff[WIDTH];

endmodule

// File: rtl/sub_arbiter.sv
// Round-robin arbiter sharing one subtractor among N_REQ valid/ready requesters;
// results leave on a single registered, tagged response channel.
module sub_arbiter
  import sub_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_borrow,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy,
  output logic [TXN_W-1:0]       txn_count
);

  arb_state_t       state_reg, state_next;
  logic [ID_W-1:0]  ptr_reg;
  logic [ID_W-1:0]  id_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [TXN_W-1:0] txn_count_reg;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_en;
  logic             accept;
  logic             complete;

  // First valid index searching ptr, ptr+1, ... modulo N_REQ; MSB flags "found".
  function automatic logic [ID_W:0] find_grant(input logic [N_REQ-1:0] valid,
                                               input logic [ID_W-1:0]  ptr);
    logic            found;
    logic [ID_W-1:0] idx;
    int              cand;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && valid[cand[ID_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[ID_W-1:0];
      end
    end
    return {found, idx};
  endfunction

  assign {grant_found, grant_idx} = find_grant(req_valid, ptr_reg);
  assign accept   = (state_reg == IDLE) && grant_found;
  assign complete = (state_reg == RESP) && rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = RESP;
      RESP:    if (rsp_ready)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; ready is also gated by rst_n so nothing is offered while held in reset
  always_comb begin
    rsp_valid = (state_reg == RESP);
    busy      = (state_reg == RESP);
    grant_en  = (state_reg == IDLE) && rst_n && grant_found;
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready[gi] = grant_en && (grant_idx == ID_W'(gi));
  end

  // Captured operands, tag, round-robin pointer and completion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      id_reg        <= '0;
      ptr_reg       <= '0;
      txn_count_reg <= '0;
    end else begin
      if (accept) begin
        a_reg  <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
        b_reg  <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
        id_reg <= grant_idx;
      end
      if (complete) begin
        ptr_reg       <= (id_reg == ID_W'(N_REQ - 1)) ? '0 : id_reg + 1'b1;
        txn_count_reg <= txn_count_reg + 1'b1;
      end
    end
  end

  subtractor #(.WIDTH(WIDTH)) u_sub (
    .A      (a_reg),
    .B      (b_reg),
    .OUT    (rsp_data),
    .BORROW (rsp_borrow)
  );

  assign rsp_id    = id_reg;
  assign txn_count = txn_count_reg;

endmodule

// File: tb/tb_sub_arbiter.sv
// Directed plus random stimulus for sub_arbiter, checked against a transaction-level
// model (pending transaction, pointer, completion count) built from the arbitration rules.
module tb_sub_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_borrow;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [15:0] txn_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_pend;
  int m_ptr, m_cnt, m_a, m_b, m_id;

  sub_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_borrow (rsp_borrow),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .txn_count  (txn_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0;
    m_ptr  = 0;
    m_cnt  = 0;
    m_a    = 0;
    m_b    = 0;
    m_id   = 0;
  endtask

  function automatic logic [31:0] lane(input int idx, input logic [7:0] val);
    logic [31:0] r;
    r = '0;
    r[idx*8 +: 8] = val;
    return r;
  endfunction

  // Drive one cycle (called at negedge), check outputs, then advance the model at posedge.
  task automatic run_cycle(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                           input logic rr);
    logic [3:0] exp_ready;
    int         g;
    int         idx;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #1;
    exp_ready = '0;
    g = -1;
    if (rst_n && !m_pend) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (g < 0 && v[idx] == 1'b1) g = idx;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_pend});
    chk("busy", {31'd0, busy}, {31'd0, m_pend});
    chk("txn_count", {16'd0, txn_count}, m_cnt);
    if (m_pend) begin
      chk("rsp_data", {24'd0, rsp_data}, (m_a - m_b + 256) % 256);
      chk("rsp_borrow", {31'd0, rsp_borrow}, (m_a < m_b) ? 1 : 0);
      chk("rsp_id", {30'd0, rsp_id}, m_id);
    end
    @(posedge clk);
    if (rst_n) begin
      if (m_pend) begin
        if (rr) begin
          $display("txn id=%0d a=0x%02h b=0x%02h diff=0x%02h borrow=%0d count=%0d",
                   m_id, m_a, m_b, (m_a - m_b + 256) % 256, (m_a < m_b), m_cnt + 1);
          m_pend = 1'b0;
          m_ptr  = (m_id + 1) % 4;
          m_cnt  = (m_cnt + 1) % 65536;
        end
      end else if (g >= 0) begin
        m_pend = 1'b1;
        m_a    = int'(a[g*8 +: 8]);
        m_b    = int'(b[g*8 +: 8]);
        m_id   = g;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);

    // Reset held with every requester valid: nothing offered, nothing produced
    run_cycle(4'hF, 32'h11223344, 32'h01020304, 1'b1);
    run_cycle(4'hF, 32'h11223344, 32'h01020304, 1'b1);
    chk("reset_rsp_data", {24'd0, rsp_data}, 0);
    chk("reset_rsp_borrow", {31'd0, rsp_borrow}, 0);
    chk("reset_rsp_id", {30'd0, rsp_id}, 0);

    // Release: requester 0 wins first
    rst_n = 1'b1;
    run_cycle(4'hF, 32'h44332211, 32'h04030201, 1'b1);
    run_cycle(4'h0, 32'h0, 32'h0, 1'b1);

    // Single requester 2: 0x50 - 0x20
    for (int i = 0; i < 3; i++) run_cycle(4'b0100, lane(2, 8'h50), lane(2, 8'h20), 1'b1);

    // Borrow cases
    for (int i = 0; i < 3; i++) run_cycle(4'b0010, lane(1, 8'h05), lane(1, 8'h0A), 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(4'b1000, lane(3, 8'h00), lane(3, 8'hFF), 1'b1);

    // Reset while a response is pending: rsp_valid drops without waiting for a clock
    run_cycle(4'b0010, lane(1, 8'h77), lane(1, 8'h11), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("midreset_busy", {31'd0, busy}, 0);
    chk("midreset_txn_count", {16'd0, txn_count}, 0);
    chk("midreset_rsp_data", {24'd0, rsp_data}, 0);
    model_reset();
    run_cycle(4'b0010, lane(1, 8'h77), lane(1, 8'h11), 1'b1);
    rst_n = 1'b1;
    run_cycle(4'h0, 32'h0, 32'h0, 1'b1);
    run_cycle(4'h0, 32'h0, 32'h0, 1'b1);

    // Fairness: ids rotate 0,1,2,3,0,1 with one result every 2 cycles
    for (int i = 0; i < 12; i++) run_cycle(4'hF, 32'hA0B0C0D0, 32'h01020304, 1'b1);

    // Backpressure: hold the response for 5 cycles, then release
    run_cycle(4'hF, 32'h10203040, 32'h50607080, 1'b0);
    for (int i = 0; i < 5; i++) run_cycle(4'hF, $urandom, $urandom, 1'b0);
    run_cycle(4'hF, 32'h0, 32'h0, 1'b1);
    run_cycle(4'hF, 32'h0, 32'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      run_cycle(4'($urandom_range(0, 15)), $urandom, $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_arbiter.md
# sub_arbiter

Round-robin arbiter that shares one combinational subtractor datapath among `N_REQ` requesters. Each requester presents an operand pair on a valid/ready channel. The arbiter grants one requester, captures its operands and drives the difference on a single tagged response channel. It sits between the stimulus-side agents and the subtractor, and replaces the single-port handshake FSM when several sources contend for the unit.

## Interface
- `N_REQ`, default 4: number of requester ports, range 2..16.
- `WIDTH`, default 8: operand and result width in bits.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester tag (derived, not overridden).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester operand valid.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit high.
- `req_a`  in  N_REQ×WIDTH  minuend per requester.
- `req_b`  in  N_REQ×WIDTH  subtrahend per requester.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  downstream accept.
- `rsp_data`  out  WIDTH  A − B modulo 2^WIDTH.
- `rsp_borrow`  out  1  unsigned A < B.
- `rsp_id`  out  ID_W  index of the requester that produced this result.
- `busy`  out  1  high while a captured transaction is in flight (state RESP).
- `txn_count`  out  16  completed response handshakes, wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, RESP.
- **IDLE**
  - Grant `g` is the first index with `req_valid[i]=1`, searching `ptr, ptr+1, …` modulo N_REQ.
  - `req_ready[g]=1` combinationally. All other `req_ready` bits are 0. With no valid request, all bits are 0.
  - On `req_valid[g]&&req_ready[g]` at a clock edge: capture `req_a[g]`, `req_b[g]` and `g` into operand/id registers, then go to RESP.
- **RESP**
  - All `req_ready` bits are 0.
  - `rsp_valid=1`.
  - `rsp_data` and `rsp_borrow` come from the subtractor driven by the captured registers and are stable for the whole state.
  - `rsp_id` is the captured `g`.
  - On `rsp_ready=1`: return to IDLE, set `ptr <= (g+1) mod N_REQ`, increment `txn_count`.
- Round-robin pointer:
  - Advances only on response completion, never on capture.
  - Wrap-around: `g = N_REQ−1` gives `ptr = 0`.
- Arithmetic:
  - `rsp_data` is a WIDTH-bit wrap of A−B.
  - `rsp_borrow` is the bit WIDTH of the (WIDTH+1)-bit difference.
  - No saturation.
- Requester inputs may change freely when not granted. A requester that drops `req_valid` before being accepted loses nothing and is not recorded.
- Reset values (asynchronous, on `rst_n=0`):
  - state IDLE, `ptr=0`;
  - `rsp_valid=0`, `rsp_data=0`, `rsp_borrow=0`, `rsp_id=0`;
  - `busy=0`, `txn_count=0`;
  - `req_ready` all 0 while `rst_n=0`.
- Reset mid-transaction (in RESP) discards the captured operands. No response is emitted after reset is released.

## Timing
- Accept at edge k. `rsp_valid` is high in the cycle after edge k (1-cycle latency).
- Response handshake at edge m. The earliest next accept is edge m+1, so the throughput is at most 1 result per 2 cycles.
- `req_ready` depends combinationally on `req_valid`, `state` and `ptr`. It does not depend on `rsp_ready`.
- `rsp_*` outputs are registered or driven from registers only. There is no combinational path from `req_*` to `rsp_*`.
- Backpressure: if `rsp_ready=0`, RESP holds indefinitely with all outputs stable.
- `txn_count` updates on the same edge as the response handshake.

## Structure
- Package `sub_arb_pkg` holds:
  - `typedef enum logic {IDLE, RESP} arb_state_t`;
  - the default `WIDTH`/`N_REQ` localparams;
  - the `txn_count` width constant.
- Sub-module `subtractor` is combinational and owns all arithmetic. It has inputs `A`, `B` and outputs `OUT` (WIDTH) and `BORROW`.
- The round-robin grant search is a function inside `sub_arbiter`, not a separate module.

## Test plan
- **Reset:** hold `rst_n=0` with all `req_valid=1`. Expect `req_ready=0000`, `rsp_valid=0` and `txn_count=0`. Release reset: requester 0 is granted first.
- **Single requester:** requester 2 sends A=0x50, B=0x20 with `rsp_ready=1`. Expect `rsp_data=0x30`, `rsp_borrow=0`, `rsp_id=2` one cycle after accept, and `txn_count=1`.
- **Borrow and wrap:** A=0x05, B=0x0A gives `rsp_data=0xFB` and `rsp_borrow=1`. A=0x00, B=0xFF gives `rsp_data=0x01` and `rsp_borrow=1`.
- **Fairness:** all four requesters are continuously valid and `rsp_ready=1`. Expect the `rsp_id` sequence 0,1,2,3,0,1 and one result every 2 cycles.
- **Backpressure:** hold `rsp_ready=0` for 5 cycles in RESP. Expect `rsp_*` stable, `req_ready` all 0 and `busy=1`. Then the handshake completes and `ptr` advances.
- **Reset mid-operation:** assert `rst_n=0` while in RESP with `rsp_valid=1`. Expect `rsp_valid` to drop immediately (asynchronously) and no stale response after release.
